nios_debug_ocimem_sequencer: RTL and testbench

Downstream consumer of the debug-slave wrapper's system-clock outputs (jdo, take_action_ocimem_*). Decodes JTAG debug commands into accesses to the on-chip debug RAM and returns MonDReg, monitor_ready and monitor_error to the debug-slave TCK logic. Also exposes an Avalon-MM slave so the CPU can reach the same RAM. JTAG traffic has priority over CPU traffic.

---
 rtl/nios_debug_ocimem_sequencer_if.sv | 48 ++++
 rtl/nios_debug_ocimem_sequencer.sv | 253 +++++++++++++++++++++++++
 tb/tb_nios_debug_ocimem_sequencer.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nios_debug_ocimem_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : nios_debug_ocimem_sequencer_if
// Description : Bundle of the JTAG command strobes, JTAG status returns and
//               the CPU Avalon-MM slave signals of the debug RAM sequencer.
//               master modport : the side driving commands/requests (debug
//                                slave wrapper + CPU)
//               slave modport  : the sequencer itself
// Parameters  : AW - debug RAM word-address width
// Revision    : 1.0 - initial release
// ============================================================================
interface nios_debug_ocimem_sequencer_if #(
    parameter int AW = 8
);
    // JTAG command side (system-clock copies from the debug slave wrapper)
    logic [37:0]   jdo;
    logic          take_action_ocimem_a;
    logic          take_no_action_ocimem_a;
    logic          take_action_ocimem_b;
    logic          debugack;
    // CPU Avalon-MM slave
    logic [AW-1:0] avs_address;
    logic          avs_read;
    logic          avs_write;
    logic [31:0]   avs_writedata;
    logic [3:0]    avs_byteenable;
    logic [31:0]   avs_readdata;
    logic          avs_waitrequest;
    // JTAG status returned to the TCK logic
    logic [31:0]   MonDReg;
    logic          monitor_ready;
    logic          monitor_error;

    modport master (
        output jdo, take_action_ocimem_a, take_no_action_ocimem_a,
               take_action_ocimem_b, debugack,
               avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
        input  avs_readdata, avs_waitrequest, MonDReg, monitor_ready, monitor_error
    );

    modport slave (
        input  jdo, take_action_ocimem_a, take_no_action_ocimem_a,
               take_action_ocimem_b, debugack,
               avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
        output avs_readdata, avs_waitrequest, MonDReg, monitor_ready, monitor_error
    );
endinterface
`default_nettype wire

// File: rtl/nios_debug_ocimem_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : nios_debug_ocimem_sequencer
// Description : Executes JTAG debug commands (address load / read / write)
//               against a 2**AW x 32 on-chip debug RAM and returns MonDReg,
//               monitor_ready and monitor_error. The CPU reaches the same RAM
//               through an Avalon-MM slave; JTAG always wins arbitration.
// Ports       : clk   - system clock
//               reset - synchronous active-high reset
//               bus   - nios_debug_ocimem_sequencer_if.slave (JTAG strobes,
//                       jdo, debugack, Avalon-MM slave, JTAG status)
// Parameters  : AW         - RAM word-address width
//               RESET_ADDR - JTAG address register value after reset
// Option      : `define DEBUG_OCIMEM_WRITE_PROTECT_EN to make CPU writes
//               while debugack=1 acknowledged but discarded.
// Revision    : 1.0 - initial release
// ============================================================================
module nios_debug_ocimem_sequencer #(
    parameter int AW         = 8,
    parameter int RESET_ADDR = 0
) (
    input  wire logic                        clk,
    input  wire logic                        reset,
    nios_debug_ocimem_sequencer_if.slave     bus
);

    localparam int            C_DEPTH    = 2 ** AW;
    localparam logic [AW-1:0] C_ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        JRD   = 3'd1,
        JCAP  = 3'd2,
        CRD   = 3'd3,
        CDONE = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        CMD_LOAD  = 2'd0,
        CMD_WRITE = 2'd1,
        CMD_READ  = 2'd2
    } cmd_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t        state_q,    state_d;
    logic [AW-1:0] addr_q,     addr_d;
    logic          pend_vld_q, pend_vld_d;
    cmd_t          pend_cmd_q, pend_cmd_d;
    logic [37:0]   pend_jdo_q, pend_jdo_d;
    logic [31:0]   mondreg_q,  mondreg_d;
    logic          ready_q,    ready_d;
    logic          error_q,    error_d;
    logic [31:0]   readdata_q, readdata_d;

    // RAM and its single access port
    logic [31:0]   mem [C_DEPTH];
    logic [31:0]   ram_rdata_q;
    logic          w_ram_we;
    logic [3:0]    w_ram_be;
    logic [31:0]   w_ram_wdata;
    logic [AW-1:0] w_ram_addr;

    // Command decode / arbitration
    logic          w_new_vld;
    cmd_t          w_new_cmd;
    logic          w_exec_vld;
    cmd_t          w_exec_cmd;
    logic [37:0]   w_exec_jdo;
    logic          w_overrun;
    logic          w_waitreq;
    logic          w_cpu_wr_allow;
    logic          w_unused_bits;

`ifdef DEBUG_OCIMEM_WRITE_PROTECT_EN
    assign w_cpu_wr_allow = ~bus.debugack;
    assign w_unused_bits  = ^{w_exec_jdo[37:36], w_exec_jdo[2:0]};
`else
    assign w_cpu_wr_allow = 1'b1;
    assign w_unused_bits  = ^{w_exec_jdo[37:36], w_exec_jdo[2:0], bus.debugack};
`endif

    // Simultaneous strobes collapse to one command: a > b > no_action_a.
    always_comb begin
        w_new_vld = bus.take_action_ocimem_a | bus.take_action_ocimem_b |
                    bus.take_no_action_ocimem_a;
        w_new_cmd = CMD_READ;
        if (bus.take_action_ocimem_a) begin
            w_new_cmd = CMD_LOAD;
        end else if (bus.take_action_ocimem_b) begin
            w_new_cmd = CMD_WRITE;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        pend_vld_d  = pend_vld_q;
        pend_cmd_d  = pend_cmd_q;
        pend_jdo_d  = pend_jdo_q;
        mondreg_d   = mondreg_q;
        ready_d     = ready_q;
        error_d     = error_q;
        readdata_d  = readdata_q;
        w_exec_vld  = 1'b0;
        w_exec_cmd  = pend_cmd_q;
        w_exec_jdo  = pend_jdo_q;
        w_overrun   = 1'b0;
        w_ram_we    = 1'b0;
        w_ram_be    = 4'hF;
        w_ram_wdata = bus.avs_writedata;
        w_ram_addr  = addr_q;
        w_waitreq   = 1'b1;

        // Pick the JTAG command to run now, or park the new one. Only one
        // command can be parked; any strobe arriving while it is occupied
        // (even in the cycle it is being drained) is an overrun.
        if (state_q == IDLE) begin
            if (pend_vld_q) begin
                w_exec_vld = 1'b1;
                pend_vld_d = 1'b0;
                w_overrun  = w_new_vld;
            end else if (w_new_vld) begin
                w_exec_vld = 1'b1;
                w_exec_cmd = w_new_cmd;
                w_exec_jdo = bus.jdo;
            end
        end else if (w_new_vld) begin
            if (pend_vld_q) begin
                w_overrun = 1'b1;
            end else begin
                pend_vld_d = 1'b1;
                pend_cmd_d = w_new_cmd;
                pend_jdo_d = bus.jdo;
            end
        end

        case (state_q)
            IDLE: begin
                if (w_exec_vld) begin
                    case (w_exec_cmd)
                        CMD_LOAD: begin
                            addr_d = w_exec_jdo[25+AW:26];
                            if (w_exec_jdo[35]) begin
                                error_d = 1'b0;
                            end
                        end
                        CMD_WRITE: begin
                            w_ram_we    = 1'b1;
                            w_ram_wdata = w_exec_jdo[34:3];
                            addr_d      = addr_q + C_ADDR_ONE;
                        end
                        default: begin
                            ready_d = 1'b0;
                            addr_d  = addr_q + C_ADDR_ONE;
                            state_d = JRD;
                        end
                    endcase
                end else if (bus.avs_read) begin
                    w_ram_addr = bus.avs_address;
                    state_d    = CRD;
                end else if (bus.avs_write) begin
                    w_ram_addr = bus.avs_address;
                    w_ram_be   = bus.avs_byteenable;
                    w_ram_we   = w_cpu_wr_allow;
                    w_waitreq  = 1'b0;
                end
            end
            // RAM data is valid here; capturing it on the way into JCAP makes
            // monitor_ready visible two cycles after the read strobe.
            JRD: begin
                mondreg_d = ram_rdata_q;
                ready_d   = 1'b1;
                state_d   = JCAP;
            end
            JCAP: begin
                state_d = IDLE;
            end
            CRD: begin
                readdata_d = ram_rdata_q;
                state_d    = CDONE;
            end
            CDONE: begin
                w_waitreq = 1'b0;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // An overrun must win over a simultaneous clear by an address load.
        if (w_overrun) begin
            error_d = 1'b1;
        end

        if (reset) begin
            w_ram_we  = 1'b0;
            w_waitreq = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= AW'(RESET_ADDR);
            pend_vld_q <= 1'b0;
            pend_cmd_q <= CMD_LOAD;
            pend_jdo_q <= '0;
            mondreg_q  <= '0;
            ready_q    <= 1'b0;
            error_q    <= 1'b0;
            readdata_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            pend_vld_q <= pend_vld_d;
            pend_cmd_q <= pend_cmd_d;
            pend_jdo_q <= pend_jdo_d;
            mondreg_q  <= mondreg_d;
            ready_q    <= ready_d;
            error_q    <= error_d;
            readdata_q <= readdata_d;
        end
    end

    // Debug RAM: byte-writable, registered read, contents survive reset.
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_ram_be[i]) begin
                    mem[w_ram_addr][8*i +: 8] <= w_ram_wdata[8*i +: 8];
                end
            end
        end
        ram_rdata_q <= mem[w_ram_addr];
    end

    assign bus.MonDReg         = mondreg_q;
    assign bus.monitor_ready   = ready_q;
    assign bus.monitor_error   = error_q;
    assign bus.avs_readdata    = readdata_q;
    assign bus.avs_waitrequest = w_waitreq;

endmodule
`default_nettype wire

// File: tb/tb_nios_debug_ocimem_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_nios_debug_ocimem_sequencer
// Description : Self-checking bench for nios_debug_ocimem_sequencer. A
//               reference RAM/address model produces expected read data that
//               is queued at stimulus time and compared when MonDReg or
//               avs_readdata is presented.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nios_debug_ocimem_sequencer;

    localparam int AW = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    nios_debug_ocimem_sequencer_if #(.AW(AW)) bus ();

    nios_debug_ocimem_sequencer #(
        .AW         (AW),
        .RESET_ADDR (0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] model_mem [256];
    logic [7:0]  model_addr = 8'h00;
    logic [31:0] exp_j [$];
    logic [31:0] exp_c [$];
    logic [31:0] sb_exp;
    logic        prev_ready = 1'b0;

    // Scoreboard: compare each produced read result with the oldest queued one.
    always @(negedge clk) begin
        if (!reset && bus.monitor_ready && !prev_ready) begin
            total++;
            if (exp_j.size() == 0) begin
                bad++;
                $display("FAIL jtag_read: got MonDReg=%h, required no result", bus.MonDReg);
            end else begin
                sb_exp = exp_j.pop_front();
                if (bus.MonDReg !== sb_exp) begin
                    bad++;
                    $display("FAIL jtag_read: got MonDReg=%h, required %h", bus.MonDReg, sb_exp);
                end
            end
        end
        prev_ready = bus.monitor_ready;
        if (!reset && bus.avs_read && !bus.avs_waitrequest) begin
            total++;
            if (exp_c.size() == 0) begin
                bad++;
                $display("FAIL cpu_read: got readdata=%h, required no result", bus.avs_readdata);
            end else begin
                sb_exp = exp_c.pop_front();
                if (bus.avs_readdata !== sb_exp) begin
                    bad++;
                    $display("FAIL cpu_read: got readdata=%h, required %h", bus.avs_readdata, sb_exp);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic jtag_load(input logic [7:0] a, input logic clr);
        bus.jdo                  = '0;
        bus.jdo[33:26]           = a;
        bus.jdo[35]              = clr;
        bus.take_action_ocimem_a = 1'b1;
        model_addr               = a;
        tick();
        bus.take_action_ocimem_a = 1'b0;
        bus.jdo                  = '0;
    endtask

    task automatic jtag_write(input logic [31:0] d);
        bus.jdo                  = '0;
        bus.jdo[34:3]            = d;
        bus.take_action_ocimem_b = 1'b1;
        model_mem[model_addr]    = d;
        model_addr               = model_addr + 8'd1;
        tick();
        bus.take_action_ocimem_b = 1'b0;
        bus.jdo                  = '0;
    endtask

    task automatic jtag_read();
        bus.take_no_action_ocimem_a = 1'b1;
        exp_j.push_back(model_mem[model_addr]);
        model_addr                  = model_addr + 8'd1;
        tick();
        bus.take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic wait_ack(input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!bus.avs_waitrequest) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s ack: got waitrequest=1 for 20 cycles, required 0", name);
        end
        tick();
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        logic protect;
        bus.avs_address    = a;
        bus.avs_writedata  = d;
        bus.avs_byteenable = be;
        bus.avs_write      = 1'b1;
`ifdef DEBUG_OCIMEM_WRITE_PROTECT_EN
        protect = bus.debugack;
`else
        protect = 1'b0;
`endif
        if (!protect) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) model_mem[a][8*i +: 8] = d[8*i +: 8];
            end
        end
        wait_ack("cpu_write");
        bus.avs_write = 1'b0;
    endtask

    task automatic cpu_read(input logic [7:0] a);
        bus.avs_address = a;
        bus.avs_read    = 1'b1;
        exp_c.push_back(model_mem[a]);
        wait_ack("cpu_read");
        bus.avs_read = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40; i++) begin
            if (exp_j.size() == 0 && exp_c.size() == 0) break;
            @(negedge clk);
            #1;
        end
        total++;
        if (exp_j.size() != 0 || exp_c.size() != 0) begin
            bad++;
            $display("FAIL %s drain: got %0d jtag / %0d cpu results outstanding, required 0",
                     name, exp_j.size(), exp_c.size());
        end
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        total += 6;
        if (bus.MonDReg !== 32'h0) begin bad++; $display("FAIL reset_mondreg: got %h, required 0", bus.MonDReg); end
        if (bus.monitor_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b, required 0", bus.monitor_ready); end
        if (bus.monitor_error !== 1'b0) begin bad++; $display("FAIL reset_error: got %b, required 0", bus.monitor_error); end
        if (bus.avs_readdata !== 32'h0) begin bad++; $display("FAIL reset_readdata: got %h, required 0", bus.avs_readdata); end
        if (bus.avs_waitrequest !== 1'b1) begin bad++; $display("FAIL reset_waitreq: got %b, required 1", bus.avs_waitrequest); end
        if (dut.addr_q !== 8'h00) begin bad++; $display("FAIL reset_addr: got %h, required 00", dut.addr_q); end
        tick();
    endtask

    task automatic test_addr_write_read();
        jtag_load(8'h10, 1'b1);
        jtag_write(32'hDEADBEEF);
        jtag_load(8'h10, 1'b0);
        jtag_read();
        @(negedge clk);
        total++;
        if (bus.monitor_ready !== 1'b0) begin
            bad++; $display("FAIL read_latency1: got ready=%b, required 0", bus.monitor_ready);
        end
        tick();
        @(negedge clk);
        total += 3;
        if (bus.monitor_ready !== 1'b1) begin bad++; $display("FAIL read_latency2: got ready=%b, required 1", bus.monitor_ready); end
        if (bus.MonDReg !== 32'hDEADBEEF) begin bad++; $display("FAIL read_data: got %h, required deadbeef", bus.MonDReg); end
        if (dut.addr_q !== 8'h11) begin bad++; $display("FAIL read_addr_inc: got %h, required 11", dut.addr_q); end
        wait_drain("addr_write_read");
    endtask

    task automatic test_wrap();
        jtag_load(8'hFF, 1'b0);
        jtag_write(32'h12345678);
        @(negedge clk);
        total++;
        if (dut.addr_q !== 8'h00) begin bad++; $display("FAIL wrap_addr: got %h, required 00", dut.addr_q); end
        tick();
        cpu_read(8'hFF);
        wait_drain("wrap");
    endtask

    task automatic test_arbitration();
        jtag_load(8'h20, 1'b0);
        bus.jdo                  = '0;
        bus.jdo[34:3]            = 32'hA5A5A5A5;
        bus.take_action_ocimem_b = 1'b1;
        bus.avs_address          = 8'h20;
        bus.avs_read             = 1'b1;
        model_mem[8'h20]         = 32'hA5A5A5A5;
        model_addr               = model_addr + 8'd1;
        exp_c.push_back(32'hA5A5A5A5);
        @(negedge clk);
        total++;
        if (bus.avs_waitrequest !== 1'b1) begin
            bad++; $display("FAIL arb_waitreq: got %b, required 1", bus.avs_waitrequest);
        end
        tick();
        bus.take_action_ocimem_b = 1'b0;
        bus.jdo                  = '0;
        wait_ack("arb_read");
        bus.avs_read = 1'b0;
        wait_drain("arbitration");
    endtask

    task automatic test_byte_enable();
        jtag_load(8'h30, 1'b0);
        jtag_write(32'h11223344);
        cpu_write(8'h30, 32'hAABBCCDD, 4'b0101);
        cpu_read(8'h30);
        jtag_load(8'h30, 1'b0);
        jtag_read();
        wait_drain("byte_enable");
    endtask

    task automatic test_overrun();
        jtag_load(8'h40, 1'b1);
        jtag_write(32'hCAFE0040);
        jtag_write(32'hCAFE0041);
        jtag_load(8'h40, 1'b0);
        jtag_read();
        jtag_read();
        // third strobe lands while the parked read is still waiting: dropped
        bus.jdo                  = '0;
        bus.jdo[34:3]            = 32'h0BAD0BAD;
        bus.take_action_ocimem_b = 1'b1;
        tick();
        bus.take_action_ocimem_b = 1'b0;
        bus.jdo                  = '0;
        @(negedge clk);
        total++;
        if (bus.monitor_error !== 1'b1) begin bad++; $display("FAIL overrun_set: got %b, required 1", bus.monitor_error); end
        wait_drain("overrun");
        total++;
        if (dut.addr_q !== 8'h42) begin bad++; $display("FAIL overrun_addr: got %h, required 42", dut.addr_q); end
        jtag_load(8'h42, 1'b0);
        @(negedge clk);
        total++;
        if (bus.monitor_error !== 1'b1) begin bad++; $display("FAIL overrun_hold: got %b, required 1", bus.monitor_error); end
        tick();
        jtag_load(8'h42, 1'b1);
        @(negedge clk);
        total++;
        if (bus.monitor_error !== 1'b0) begin bad++; $display("FAIL overrun_clear: got %b, required 0", bus.monitor_error); end
        tick();
        // the dropped write must not have reached RAM
        jtag_write(32'h00000000);
        jtag_load(8'h41, 1'b0);
        jtag_read();
        wait_drain("overrun_ram");
    endtask

    task automatic test_reset_mid_read();
        jtag_load(8'h10, 1'b0);
        jtag_read();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        total += 4;
        if (bus.monitor_ready !== 1'b0) begin bad++; $display("FAIL midrst_ready: got %b, required 0", bus.monitor_ready); end
        if (bus.MonDReg !== 32'h0) begin bad++; $display("FAIL midrst_mondreg: got %h, required 0", bus.MonDReg); end
        if (bus.avs_waitrequest !== 1'b1) begin bad++; $display("FAIL midrst_waitreq: got %b, required 1", bus.avs_waitrequest); end
        if (dut.addr_q !== 8'h00) begin bad++; $display("FAIL midrst_addr: got %h, required 00", dut.addr_q); end
        exp_j.delete();
        model_addr = 8'h00;
        tick();
        cpu_read(8'h10);
        wait_drain("reset_mid_read");
    endtask

    task automatic test_write_protect();
        jtag_load(8'h05, 1'b0);
        jtag_write(32'h11112222);
        bus.debugack = 1'b1;
        cpu_write(8'h05, 32'hFFFFFFFF, 4'hF);
        bus.debugack = 1'b0;
        jtag_load(8'h05, 1'b0);
        jtag_read();
        wait_drain("write_protect");
    endtask

    initial begin
        for (int i = 0; i < 256; i++) model_mem[i] = 32'h0;
        bus.jdo                     = '0;
        bus.take_action_ocimem_a    = 1'b0;
        bus.take_no_action_ocimem_a = 1'b0;
        bus.take_action_ocimem_b    = 1'b0;
        bus.debugack                = 1'b0;
        bus.avs_address             = '0;
        bus.avs_read                = 1'b0;
        bus.avs_write               = 1'b0;
        bus.avs_writedata           = '0;
        bus.avs_byteenable          = 4'h0;

        test_reset();
        test_addr_write_read();
        test_wrap();
        test_arbitration();
        test_byte_enable();
        test_overrun();
        test_reset_mid_read();
        test_write_protect();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
